// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage, the write-back stage and the register-file write port.
interface wb_stage_if;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_alu;
    logic [31:0] m_rdata;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        load_err;
    logic [31:0] retired;

    modport master (
        output m_valid, m_pc, m_instr, m_alu, m_rdata, stall, flush,
        input  wb_we, wb_addr, wb_data, wb_pc, load_err, retired
    );

    modport slave (
        input  m_valid, m_pc, m_instr, m_alu, m_rdata, stall, flush,
        output wb_we, wb_addr, wb_data, wb_pc, load_err, retired
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load alignment/extension, register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter logic [4:0]  RA_REG      = 5'd31,
    parameter logic [31:0] PC_LINK_OFS = 32'd8
) (
    input  logic     clk,
    input  logic     rst,
    wb_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] alu_reg;
    logic [31:0] rdata_reg;
    logic        load_err_reg;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
            alu_reg   <= '0;
            rdata_reg <= '0;
        end else if (!bus.stall) begin
            valid_reg <= bus.m_valid;
            pc_reg    <= bus.m_pc;
            instr_reg <= bus.m_instr;
            alu_reg   <= bus.m_alu;
            rdata_reg <= bus.m_rdata;
        end
    end

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [1:0] ofs;
    logic       unused_instr_bits;

    assign op    = instr_reg[31:26];
    assign funct = instr_reg[5:0];
    assign rt    = instr_reg[20:16];
    assign rd    = instr_reg[15:11];
    assign ofs   = alu_reg[1:0];
    assign unused_instr_bits = ^{instr_reg[25:21], instr_reg[10:6]};

    // Memory is big-endian: lane 0 is the most significant byte.
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata_reg[8*(3-gi) +: 8];
        end
    endgenerate

    assign byte_sel = lane[ofs];
    assign half_sel = ofs[1] ? rdata_reg[15:0] : rdata_reg[31:16];

    logic        writes;
    logic        misalign;
    logic [4:0]  dest;
    logic [31:0] data_sel;

    always_comb begin
        writes   = 1'b0;
        misalign = 1'b0;
        dest     = rt;
        data_sel = alu_reg;
        case (op)
            OP_RTYPE: begin
                dest   = rd;
                writes = (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLL);
            end
            OP_ORI, OP_LUI: writes = 1'b1;
            OP_JAL: begin
                writes   = 1'b1;
                dest     = RA_REG;
                data_sel = pc_reg + PC_LINK_OFS;
            end
            OP_LW: begin
                writes   = 1'b1;
                misalign = (ofs != 2'd0);
                data_sel = rdata_reg;
            end
            OP_LB: begin
                writes   = 1'b1;
                data_sel = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                writes   = 1'b1;
                data_sel = {24'd0, byte_sel};
            end
            OP_LH: begin
                writes   = 1'b1;
                misalign = ofs[0];
                data_sel = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                writes   = 1'b1;
                misalign = ofs[0];
                data_sel = {16'd0, half_sel};
            end
            default: ;
        endcase
    end

    // Address and data must be zero when not writing: the register file forwards on address match.
    logic we_int;
    assign we_int      = valid_reg && writes && !misalign && (dest != 5'd0);
    assign bus.wb_we   = we_int;
    assign bus.wb_addr = we_int ? dest     : 5'd0;
    assign bus.wb_data = we_int ? data_sel : 32'd0;
    assign bus.wb_pc   = we_int ? pc_reg   : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err_reg <= 1'b0;
        end else if (valid_reg && misalign) begin
            load_err_reg <= 1'b1;
        end
    end
    assign bus.load_err = load_err_reg;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (valid_reg && (!bus.stall || bus.flush)) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end
    assign bus.retired = retired_reg;
`else
    assign bus.retired = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a field-level reference model.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if bus();
    wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %08h required %08h", tag, got, exp);
    endtask

    // Reference view of the instruction currently retiring.
    logic        ref_valid;
    logic [31:0] ref_pc, ref_instr, ref_alu, ref_rdata;
    logic        ref_err;
    logic [31:0] ref_ret;

    function automatic void expect_write(input logic v, input logic [31:0] pc, instr, alu, rdata,
                                         output logic we, output logic [31:0] addr,
                                         output logic [31:0] data, output logic bad);
        int unsigned op, funct, rt, rd, ofs, b, h;
        logic wr;
        op    = instr / (2**26);
        funct = instr % 64;
        rt    = (instr / (2**16)) % 32;
        rd    = (instr / (2**11)) % 32;
        ofs   = alu % 4;
        b     = (rdata / (2**(8*(3-ofs)))) % 256;
        h     = (ofs >= 2) ? rdata % 65536 : rdata / 65536;
        wr = 1'b1; bad = 1'b0; addr = rt; data = alu;
        if (op == 0) begin
            addr = rd;
            wr = (funct == 33 || funct == 35 || funct == 0);
        end else if (op == 13 || op == 15) begin
        end else if (op == 3) begin
            addr = 31; data = pc + 32'd8;
        end else if (op == 35) begin
            data = rdata; bad = (ofs != 0);
        end else if (op == 32 || op == 36) begin
            data = (op == 32 && b >= 128) ? b + 32'hFFFFFF00 : b;
        end else if (op == 33 || op == 37) begin
            bad = (ofs % 2 == 1);
            data = (op == 33 && h >= 32768) ? h + 32'hFFFF0000 : h;
        end else begin
            wr = 1'b0;
        end
        bad = bad && v;
        we = v && wr && !bad && (addr != 0);
        if (!we) begin addr = 0; data = 0; end
    endfunction

    task automatic cycle(input string tag, input logic v, input logic [31:0] pc, instr, alu, rdata,
                         input logic st, input logic fl, input logic r);
        logic we, bad;
        logic [31:0] a, d, exp_ret;
        bus.m_valid = v; bus.m_pc = pc; bus.m_instr = instr; bus.m_alu = alu; bus.m_rdata = rdata;
        bus.stall = st; bus.flush = fl; rst = r;
        @(posedge clk);
        if (r) begin
            ref_valid = 0; ref_pc = 0; ref_instr = 0; ref_alu = 0; ref_rdata = 0;
            ref_err = 0; ref_ret = 0;
        end else begin
            expect_write(ref_valid, ref_pc, ref_instr, ref_alu, ref_rdata, we, a, d, bad);
            if (bad) ref_err = 1;
            if (ref_valid && (!st || fl)) ref_ret = ref_ret + 1;
            if (fl) begin
                ref_valid = 0; ref_pc = 0; ref_instr = 0; ref_alu = 0; ref_rdata = 0;
            end else if (!st) begin
                ref_valid = v; ref_pc = pc; ref_instr = instr; ref_alu = alu; ref_rdata = rdata;
            end
        end
        @(negedge clk);
        expect_write(ref_valid, ref_pc, ref_instr, ref_alu, ref_rdata, we, a, d, bad);
`ifdef WB_RETIRE_CNT_EN
        exp_ret = ref_ret;
`else
        exp_ret = 0;
`endif
        check({tag, ".we"},       {31'd0, bus.wb_we},    {31'd0, we});
        check({tag, ".addr"},     {27'd0, bus.wb_addr},  a);
        check({tag, ".data"},     bus.wb_data,           d);
        check({tag, ".pc"},       bus.wb_pc,             we ? ref_pc : 32'd0);
        check({tag, ".load_err"}, {31'd0, bus.load_err}, {31'd0, ref_err});
        check({tag, ".retired"},  bus.retired,           exp_ret);
        $display("%-8s rst=%0d st=%0d fl=%0d | we=%0d addr=%0d data=%08h pc=%08h err=%0d ret=%0d",
                 tag, r, st, fl, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_pc, bus.load_err, bus.retired);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [31:0] ins;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  ins = {6'h00, r[25:6], 6'h21};
            1:  ins = {6'h00, r[25:6], 6'h23};
            2:  ins = {6'h00, r[25:6], 6'h00};
            3:  ins = {6'h00, r[25:6], 6'h08};
            4:  ins = {6'h0d, r[25:0]};
            5:  ins = {6'h0f, r[25:0]};
            6:  ins = {6'h03, r[25:0]};
            7:  ins = {6'h23, r[25:0]};
            8:  ins = {6'h20, r[25:0]};
            9:  ins = {6'h24, r[25:0]};
            10: ins = {6'h21, r[25:0]};
            11: ins = {6'h25, r[25:0]};
            12: ins = {6'h2b, r[25:0]};
            default: ins = r;
        endcase
        return ins;
    endfunction

    localparam logic [31:0] ORI5 = 32'h34051234;
    localparam logic [31:0] NOPW = 32'h00000000;

    initial begin
        cycle("reset", 1, 32'h100, ORI5, 32'h1234, 32'h0, 0, 0, 1);
        cycle("reset", 0, 0, 0, 0, 0, 0, 0, 1);

        cycle("ori", 1, 32'h3000, ORI5, 32'h1234, 32'hDEADBEEF, 0, 0, 0);
        check("ori_const.we", {31'd0, bus.wb_we}, 32'd1);
        check("ori_const.addr", {27'd0, bus.wb_addr}, 32'd5);
        check("ori_const.data", bus.wb_data, 32'h00001234);
        check("ori_const.pc", bus.wb_pc, 32'h00003000);
        cycle("lb", 1, 32'h3004, 32'h80080000, 32'h10000001, 32'h11F23344, 0, 0, 0);
        check("lb_const.data", bus.wb_data, 32'hFFFFFFF2);
        cycle("lbu", 1, 32'h3008, 32'h90080000, 32'h10000001, 32'h11F23344, 0, 0, 0);
        check("lbu_const.data", bus.wb_data, 32'h000000F2);
        cycle("lhu", 1, 32'h300C, 32'h94080000, 32'h10000002, 32'h11F23344, 0, 0, 0);
        check("lhu_const.data", bus.wb_data, 32'h00003344);
        cycle("jal", 1, 32'h3010, 32'h0C000C00, 32'h0, 32'h0, 0, 0, 0);
        check("jal_const.addr", {27'd0, bus.wb_addr}, 32'd31);
        check("jal_const.data", bus.wb_data, 32'h00003018);
        cycle("jr", 1, 32'h3014, 32'h03E00008, 32'h3018, 32'h0, 0, 0, 0);
        cycle("sw", 1, 32'h3018, 32'hAD090000, 32'h1000, 32'h55, 0, 0, 0);
        check("sw_const.data", bus.wb_data, 32'h0);
        cycle("addu_r0", 1, 32'h301C, 32'h00220021, 32'h77, 32'h0, 0, 0, 0);
        check("addu_r0_const.addr", {27'd0, bus.wb_addr}, 32'd0);
        cycle("lw_mis", 1, 32'h3020, 32'h8C090000, 32'h10000002, 32'h12345678, 0, 0, 0);
        for (int i = 0; i < 11; i++)
            cycle("after", 1, 32'h3024 + 4*i, ORI5, 32'h1234, 32'h0, 0, 0, 0);
        check("err_sticky_const", {31'd0, bus.load_err}, 32'd1);

        cycle("stall_ld", 1, 32'h3100, 32'h34060055, 32'h55, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1, 32'h3200, 32'h0C000000, 32'h0, 32'h0, 1, 0, 0);
            check("stall_const.addr", {27'd0, bus.wb_addr}, 32'd6);
        end
        cycle("fl_st", 1, 32'h3300, ORI5, 32'h1234, 32'h0, 1, 1, 0);
        check("flush_const.we", {31'd0, bus.wb_we}, 32'd0);
        cycle("pre_rst", 1, 32'h3400, ORI5, 32'h1234, 32'h0, 0, 0, 0);
        cycle("rst_mid", 1, 32'h3404, ORI5, 32'h1234, 32'h0, 0, 0, 1);
        check("rst_const.err", {31'd0, bus.load_err}, 32'd0);
        check("rst_const.data", bus.wb_data, 32'd0);

        cycle("ret", 1, 32'h4000, ORI5, 32'h1, 32'h0, 0, 0, 0);
        cycle("ret", 1, 32'h4004, ORI5, 32'h2, 32'h0, 0, 0, 0);
        cycle("ret", 0, 32'h0, NOPW, 32'h0, 32'h0, 0, 0, 0);
        cycle("ret", 1, 32'h4008, 32'h8C090000, 32'h3, 32'h0, 0, 0, 0);
        cycle("ret_st", 1, 32'h9999, ORI5, 32'h9, 32'h0, 1, 0, 0);
        cycle("ret_st", 1, 32'h9999, ORI5, 32'h9, 32'h0, 1, 0, 0);
        cycle("ret", 1, 32'h400C, ORI5, 32'h4, 32'h0, 0, 0, 0);
        cycle("ret", 0, 32'h0, NOPW, 32'h0, 32'h0, 0, 0, 0);
        cycle("ret", 1, 32'h4010, ORI5, 32'h5, 32'h0, 0, 0, 0);
        cycle("ret", 0, 32'h0, NOPW, 32'h0, 32'h0, 0, 0, 0);
`ifdef WB_RETIRE_CNT_EN
        check("retired_const", bus.retired, 32'd5);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 9) != 0), $urandom, rand_instr(), $urandom, $urandom,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
